// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, opcode field, reset PC.
package ifu_fetch_pkg;

    localparam int          FETCH_XLEN     = 32;

    // RISC-V major opcode field lives in instr[6:0]
    localparam int          OPC_LSB        = 0;
    localparam int          OPC_MSB        = 6;
    localparam int          OPC_W          = OPC_MSB - OPC_LSB + 1;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {instr, pc} pairs.
module ifu_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;

    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    // Pointer / occupancy update; flush discards everything, including a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array, no reset needed: contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // Upstream credit logic must never overrun the buffer.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, ROM read credits, redirect kill, and decode-side buffer.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              IMEM_AW  = 10,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [XLEN-1:0]    dec_instr,
    output logic [XLEN-1:0]    dec_pc,
    output logic [OPC_W-1:0]   dec_opcode
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic              inflight;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occ;
    logic [2*XLEN-1:0] head;
    logic              push;
    logic              pop;
    logic              unused_rpc_lo;

    assign unused_rpc_lo = ^redirect_pc[1:0];

    // Buffered entries plus the outstanding read must leave room for one more response.
    assign occ        = OW'(count) + OW'(inflight);
    assign imem_rd_en = !rst && !redirect_valid && (occ < OW'(DEPTH));
    assign imem_addr  = pc[IMEM_AW+1:2];

    // A redirect kills the response landing this cycle and any pop decode attempts.
    assign push       = inflight && !redirect_valid;
    assign pop        = dec_valid && dec_ready && !redirect_valid;

    // PC and in-flight tracking; a cleared inflight flag is what drops stale responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (imem_rd_en) begin
            pc       <= pc + XLEN'(4);
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    ifu_fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_rdata, req_pc}),
        .count (count),
        .head  (head)
    );

    assign dec_valid  = (count != '0);
    assign dec_instr  = dec_valid ? head[2*XLEN-1:XLEN] : '0;
    assign dec_pc     = dec_valid ? head[XLEN-1:0]      : '0;
    assign dec_opcode = dec_instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized + directed bench for ifu_fetch against a queue-based fetch model.
module tb_ifu_fetch;

    localparam int          XLEN  = 32;
    localparam int          AW    = 10;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_rd_en;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [6:0]      dec_opcode;

    // second instance for the PC wrap scenario
    logic            w_rd_en;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_rdata;
    logic            w_rv  = 1'b0;
    logic [XLEN-1:0] w_rpc = '0;
    logic            w_rdy = 1'b1;
    logic            w_valid;
    logic [XLEN-1:0] w_instr;
    logic [XLEN-1:0] w_pc;
    logic [6:0]      w_opc;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(XLEN), .IMEM_AW(AW), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_opcode(dec_opcode));

    ifu_fetch #(.XLEN(XLEN), .IMEM_AW(AW), .RESET_PC(WPC), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst), .imem_rd_en(w_rd_en), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect_valid(w_rv), .redirect_pc(w_rpc),
        .dec_valid(w_valid), .dec_ready(w_rdy), .dec_instr(w_instr),
        .dec_pc(w_pc), .dec_opcode(w_opc));

    // ROM word n holds n; synchronous read, not reset
    always @(posedge clk) if (imem_rd_en) imem_rdata <= {22'h0, imem_addr};
    always @(posedge clk) if (w_rd_en)    w_rdata    <= {22'h0, w_addr};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] q[$];      // PCs visible to decode, oldest first
    bit          m_fly;
    logic [31:0] m_fly_pc;

    function automatic logic [31:0] rom(input logic [31:0] p);
        return {22'h0, p[11:2]};
    endfunction

    function automatic bit m_issue(input logic rv);
        return !rv && ((q.size() + int'(m_fly)) < DEPTH);
    endfunction

    task automatic m_reset();
        m_pc = RPC; q.delete(); m_fly = 0;
    endtask

    task automatic m_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit iss;
        iss = m_issue(rv);
        if (rv) begin
            q.delete(); m_fly = 0; m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (m_fly) q.push_back(m_fly_pc);
            if (iss) begin m_fly = 1; m_fly_pc = m_pc; m_pc = m_pc + 32'd4; end
            else m_fly = 0;
        end
    endtask

    // ---------------- per-cycle driver/checker ----------------
    logic [31:0] acc[$];    // PCs accepted by decode (not squashed)
    logic        last_vld, last_rd;
    logic [31:0] last_pc;

    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] e_pc, e_in;
        @(negedge clk);
        redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
        #1;
        e_pc = (q.size() != 0) ? q[0] : 32'h0;
        e_in = (q.size() != 0) ? rom(q[0]) : 32'h0;
        chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
        chk("dec_pc", dec_pc, e_pc);
        chk("dec_instr", dec_instr, e_in);
        chk("dec_opcode", 32'(dec_opcode), 32'(e_in[6:0]));
        chk("imem_rd_en", 32'(imem_rd_en), 32'(m_issue(rv)));
        if (imem_rd_en) chk("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
        if (dec_valid && dec_ready && !rv) acc.push_back(dec_pc);
        last_vld = dec_valid; last_rd = imem_rd_en; last_pc = dec_pc;
        @(posedge clk);
        m_step(rv, rpc, rdy);
    endtask

    // Assert reset just after an edge, check outputs immediately, release before the next edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_valid"}, 32'(dec_valid), 32'h0);
        chk({tag, "_rd_en"}, 32'(imem_rd_en), 32'h0);
        chk({tag, "_instr"}, dec_instr, 32'h0);
        chk({tag, "_pc"}, dec_pc, 32'h0);
        m_reset();
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc.size() > i) ? acc[i] : 32'hDEAD_BEEF;
    endfunction

    // wrap instance: record first three presented PCs / instructions
    logic [31:0] w_seen[$];
    logic [31:0] w_seen_in[$];
    always @(negedge clk)
        if (!rst && w_valid && w_seen.size() < 3) begin
            w_seen.push_back(w_pc);
            w_seen_in.push_back(w_instr);
        end

    initial begin
        int fr, fv;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // streaming from reset: latency and in-order sequence
        acc.delete(); fr = -1; fv = -1;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (last_rd && fr < 0) fr = k;
            if (last_vld && fv < 0) fv = k;
        end
        chk("first_vld_lat", 32'(fv - fr), 32'd2);
        for (int i = 0; i < 4; i++) chk("stream_pc", acc_at(i), 32'(4 * i));

        // stall: head holds, credits stop issue, resume without loss
        do_reset("rst1");
        for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b0);
        chk("stall_pc", last_pc, 32'h0);
        chk("stall_rd_en", 32'(last_rd), 32'h0);
        acc.delete();
        for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) chk("resume_pc", acc_at(i), 32'(4 * i));

        // redirect with a full buffer, unaligned target
        do_reset("rst2");
        for (int k = 0; k < 5; k++) cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 32'h0000_0103, 1'b0);
        acc.delete(); fv = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (last_vld && fv < 0) fv = k;
        end
        chk("redir_lat", 32'(fv), 32'd3);
        chk("redir_pc0", acc_at(0), 32'h100);
        chk("redir_pc1", acc_at(1), 32'h104);
        foreach (acc[i]) chk("redir_no_old", 32'(acc[i] >= 32'h100), 32'h1);

        // redirect coinciding with a pop, streaming state (entry buffered + read in flight)
        for (int k = 0; k < 2; k++) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'h0000_0200, 1'b1);
        acc.delete();
        for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1);
        chk("pop_redir_pc0", acc_at(0), 32'h200);
        chk("pop_redir_pc1", acc_at(1), 32'h204);

        // random traffic
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 11) == 0, $urandom & 32'h0000_0FFF, $urandom_range(0, 3) != 0);

        // async reset mid-stream with a read in flight; stale response must be dropped
        for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1);
        do_reset("rst_mid");
        acc.delete();
        for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1);
        chk("restart_pc0", acc_at(0), RPC);
        chk("restart_pc1", acc_at(1), RPC + 32'd4);

        // PC wrap instance
        chk("wrap_count", 32'(w_seen.size()), 32'd3);
        if (w_seen.size() == 3) begin
            chk("wrap_pc0", w_seen[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", w_seen[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", w_seen[2], 32'h0000_0000);
            chk("wrap_in0", w_seen_in[0], 32'h0000_03FE);
            chk("wrap_in2", w_seen_in[2], 32'h0000_0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
